// File: rtl/ct_rtu_encode_ff.sv
// Retire-unit index encoder: one-hot OR-encode or rotating find-first-set over a WIDTH-bit entry vector.
// Latency: 2 cycles (S1 input register, S2 result register); a new request can be accepted every cycle.
// Backpressure: a stalled S2 holds its result stable; x_ready_out drops only when both stages are full.
//
// Ports:
//   forever_cpuclk / cpurst          clock and synchronous active-high reset
//   x_vld_in / x_ready_out           request handshake (x_num_expand, x_base_ptr, x_mode)
//   x_num_vld / x_num_ready          result handshake (x_num, x_hit, x_multi, x_wrap)
module ct_rtu_encode_ff #(
    parameter int WIDTH = 96,
    parameter int IDX_W = 7
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             x_vld_in,
    output logic             x_ready_out,
    input  logic [WIDTH-1:0] x_num_expand,
    input  logic [IDX_W-1:0] x_base_ptr,
    input  logic             x_mode,
    output logic             x_num_vld,
    input  logic             x_num_ready,
    output logic [IDX_W-1:0] x_num,
    output logic             x_hit,
    output logic             x_multi,
    output logic             x_wrap
);

    // WIDTH may equal 2^IDX_W, so the limit needs one extra bit.
    localparam logic [IDX_W:0] W_LIMIT = (IDX_W+1)'(WIDTH);

    // Stage S1 state
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_vec;
    logic [IDX_W-1:0] r_s1_base;
    logic             r_s1_mode;

    // Stage S2 state (drives the outputs)
    logic             r_s2_vld;
    logic [IDX_W-1:0] r_num;
    logic             r_hit;
    logic             r_multi;
    logic             r_wrap;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;
    logic [IDX_W-1:0] w_eff_base;

    logic [IDX_W-1:0] w_or_idx;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_lo_idx;
    logic             w_hi_fnd;
    logic             w_seen;
    logic             w_multi_c;
    logic [IDX_W-1:0] w_num;
    logic             w_wrap;

    assign w_s2_adv    = !r_s2_vld | x_num_ready;
    assign w_s1_adv    = r_s1_vld & w_s2_adv;
    assign x_ready_out = !cpurst & (!r_s1_vld | w_s2_adv);
    assign w_accept    = x_vld_in & x_ready_out;

    // Out-of-range base pointers fall back to entry 0.
    assign w_eff_base = ({1'b0, x_base_ptr} < W_LIMIT) ? x_base_ptr : '0;

    // Scanning from the top down leaves the lowest set index in w_lo_idx and the
    // lowest set index at-or-above base in w_hi_idx. A rotating search returns
    // w_hi_idx if one exists, otherwise it wrapped and returns w_lo_idx.
    always_comb begin
        w_or_idx  = '0;
        w_hi_idx  = '0;
        w_lo_idx  = '0;
        w_hi_fnd  = 1'b0;
        w_seen    = 1'b0;
        w_multi_c = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_s1_vec[i]) begin
                w_or_idx  = w_or_idx | IDX_W'(i);
                w_multi_c = w_multi_c | w_seen;
                w_seen    = 1'b1;
                w_lo_idx  = IDX_W'(i);
                if (IDX_W'(i) >= r_s1_base) begin
                    w_hi_idx = IDX_W'(i);
                    w_hi_fnd = 1'b1;
                end
            end
        end
        w_num  = r_s1_mode ? (w_hi_fnd ? w_hi_idx : w_lo_idx) : w_or_idx;
        w_wrap = r_s1_mode & w_seen & !w_hi_fnd;
    end

    // S1 valid: whenever S1 can take a new item it either loads the request
    // or empties (its previous item, if any, is moving to S2 this edge).
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_s1_vld <= 1'b0;
        end else if (x_ready_out) begin
            r_s1_vld <= x_vld_in;
        end
    end

    // S1 payload loads only on accept so stalled data does not toggle.
    always_ff @(posedge forever_cpuclk) begin
        if (w_accept) begin
            r_s1_vec  <= x_num_expand;
            r_s1_base <= w_eff_base;
            r_s1_mode <= x_mode;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_s2_vld <= 1'b0;
            r_num    <= '0;
            r_hit    <= 1'b0;
            r_multi  <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_s2_vld <= r_s1_vld;
            end
            if (w_s1_adv) begin
                r_num   <= w_num;
                r_hit   <= w_seen;
                r_multi <= w_multi_c;
                r_wrap  <= w_wrap;
            end
        end
    end

    assign x_num_vld = r_s2_vld;
    assign x_num     = r_num;
    assign x_hit     = r_hit;
    assign x_multi   = r_multi;
    assign x_wrap    = r_wrap;

endmodule

// File: tb/tb_ct_rtu_encode_ff.sv
module tb_ct_rtu_encode_ff;

    typedef struct packed {
        logic [6:0] num;
        logic       hit;
        logic       multi;
        logic       wrap;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default WIDTH=96, IDX_W=7
    logic        a_vld, a_rdy_out, a_mode, a_num_vld, a_num_rdy, a_hit, a_multi, a_wrap;
    logic [95:0] a_vec;
    logic [6:0]  a_base, a_num;
    // Instance B: WIDTH=16, IDX_W=4
    logic        b_vld, b_rdy_out, b_mode, b_num_vld, b_num_rdy, b_hit, b_multi, b_wrap;
    logic [15:0] b_vec;
    logic [3:0]  b_base, b_num;

    res_t a_got, b_got;
    assign a_got = {a_num, a_hit, a_multi, a_wrap};
    assign b_got = {3'b000, b_num, b_hit, b_multi, b_wrap};

    int n_tests = 0;
    int n_fail  = 0;

    res_t q_a[$];
    res_t q_b[$];

    ct_rtu_encode_ff dut_a (
        .forever_cpuclk(clk), .cpurst(rst),
        .x_vld_in(a_vld), .x_ready_out(a_rdy_out),
        .x_num_expand(a_vec), .x_base_ptr(a_base), .x_mode(a_mode),
        .x_num_vld(a_num_vld), .x_num_ready(a_num_rdy),
        .x_num(a_num), .x_hit(a_hit), .x_multi(a_multi), .x_wrap(a_wrap)
    );

    ct_rtu_encode_ff #(.WIDTH(16), .IDX_W(4)) dut_b (
        .forever_cpuclk(clk), .cpurst(rst),
        .x_vld_in(b_vld), .x_ready_out(b_rdy_out),
        .x_num_expand(b_vec), .x_base_ptr(b_base), .x_mode(b_mode),
        .x_num_vld(b_num_vld), .x_num_ready(b_num_rdy),
        .x_num(b_num), .x_hit(b_hit), .x_multi(b_multi), .x_wrap(b_wrap)
    );

    // Reference: explicit rotating walk from the effective base, popcount for flags.
    function automatic res_t model(input logic [95:0] vec, input int base, input logic mode);
        res_t r;
        int   cnt;
        int   eb;
        int   idx;
        r   = '0;
        cnt = 0;
        eb  = (base < 96) ? base : 0;
        for (int i = 0; i < 96; i++) begin
            if (vec[i]) begin
                cnt++;
                if (!mode) r.num = r.num | 7'(i);
            end
        end
        if (mode) begin
            for (int k = 95; k >= 0; k--) begin
                idx = (eb + k) % 96;
                if (vec[idx]) begin
                    r.num  = 7'(idx);
                    r.wrap = (idx < eb);
                end
            end
        end
        r.hit   = (cnt > 0);
        r.multi = (cnt > 1);
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        a_vld = 1'b1; a_vec = 96'h1; a_base = '0; a_mode = 1'b0; a_num_rdy = 1'b1;
        b_vld = 1'b1; b_vec = 16'h1; b_base = '0; b_mode = 1'b0; b_num_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (a_rdy_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready_a got=%b exp=0", a_rdy_out); end
        n_tests++;
        if ({a_num_vld, a_got} !== 11'd0) begin n_fail++; $display("FAIL reset_outputs_a got=%b exp=0", {a_num_vld, a_got}); end
        n_tests++;
        if ({b_num_vld, b_got} !== 11'd0) begin n_fail++; $display("FAIL reset_outputs_b got=%b exp=0", {b_num_vld, b_got}); end
        @(negedge clk);
        rst = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
        #1;
        n_tests++;
        if (a_rdy_out !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got=%b exp=1", a_rdy_out); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            n_tests++;
            if ({a_num_vld, b_num_vld} !== 2'b00) begin
                n_fail++; $display("FAIL reset_req_ignored cyc=%0d got=%b exp=00", c, {a_num_vld, b_num_vld});
            end
        end
    endtask

    task automatic test_walk;
        int   acc_q[$];
        int   sent = 0;
        int   got  = 0;
        int   acc;
        res_t e;
        a_num_rdy = 1'b1;
        for (int c = 0; c < 200 && got < 96; c++) begin
            @(negedge clk);
            a_vld = (sent < 96); a_vec = '0;
            if (sent < 96) a_vec[sent] = 1'b1;
            a_base = '0; a_mode = 1'b0;
            #1;
            if (a_vld && a_rdy_out) begin
                q_a.push_back(model(a_vec, 0, 1'b0)); acc_q.push_back(cyc); sent++;
            end
            if (a_num_vld && a_num_rdy) begin
                n_tests++;
                if (q_a.size() == 0) begin
                    n_fail++; $display("FAIL walk_extra got=%h", a_got);
                end else begin
                    e = q_a.pop_front(); acc = acc_q.pop_front();
                    if (a_got !== e || (cyc - acc) != 2) begin
                        n_fail++; $display("FAIL walk_result got=%h lat=%0d exp=%h lat=2", a_got, cyc - acc, e);
                    end
                end
                got++;
            end
        end
        a_vld = 1'b0;
        n_tests++;
        if (got != 96) begin n_fail++; $display("FAIL walk_timeout got=%0d exp=96", got); end
    endtask

    task automatic test_rotate;
        logic [95:0] tv[10];
        logic [6:0]  tbase[10];
        logic        tmode[10];
        res_t        te[10];
        logic [95:0] v5_40, v95, v0;
        int          sent = 0;
        int          got  = 0;
        res_t        e;
        v5_40 = '0; v5_40[5] = 1'b1; v5_40[40] = 1'b1;
        v95 = '0; v95[95] = 1'b1;
        v0 = '0; v0[0] = 1'b1;
        tv[0] = v5_40; tbase[0] = 7'd10;  tmode[0] = 1'b1; te[0] = {7'd40, 3'b110};
        tv[1] = v5_40; tbase[1] = 7'd41;  tmode[1] = 1'b1; te[1] = {7'd5,  3'b111};
        tv[2] = v5_40; tbase[2] = 7'd40;  tmode[2] = 1'b1; te[2] = {7'd40, 3'b110};
        tv[3] = v95;   tbase[3] = 7'd120; tmode[3] = 1'b1; te[3] = {7'd95, 3'b100};
        tv[4] = '0;    tbase[4] = 7'd0;   tmode[4] = 1'b0; te[4] = {7'd0,  3'b000};
        tv[5] = '0;    tbase[5] = 7'd50;  tmode[5] = 1'b1; te[5] = {7'd0,  3'b000};
        tv[6] = v5_40; tbase[6] = 7'd0;   tmode[6] = 1'b0; te[6] = {7'd45, 3'b110};
        tv[7] = v5_40; tbase[7] = 7'd95;  tmode[7] = 1'b1; te[7] = {7'd5,  3'b111};
        tv[8] = v95;   tbase[8] = 7'd95;  tmode[8] = 1'b1; te[8] = {7'd95, 3'b100};
        tv[9] = v0;    tbase[9] = 7'd1;   tmode[9] = 1'b1; te[9] = {7'd0,  3'b101};
        a_num_rdy = 1'b1;
        for (int c = 0; c < 60 && got < 10; c++) begin
            @(negedge clk);
            a_vld = (sent < 10);
            if (sent < 10) begin a_vec = tv[sent]; a_base = tbase[sent]; a_mode = tmode[sent]; end
            #1;
            if (a_vld && a_rdy_out) begin q_a.push_back(te[sent]); sent++; end
            if (a_num_vld && a_num_rdy) begin
                n_tests++;
                if (q_a.size() == 0) begin
                    n_fail++; $display("FAIL rotate_extra got=%h", a_got);
                end else begin
                    e = q_a.pop_front();
                    if (a_got !== e) begin n_fail++; $display("FAIL rotate_case%0d got=%h exp=%h", got, a_got, e); end
                end
                got++;
            end
        end
        a_vld = 1'b0;
        n_tests++;
        if (got != 10) begin n_fail++; $display("FAIL rotate_timeout got=%0d exp=10", got); end
    endtask

    task automatic test_backpressure;
        int   sent = 0;
        int   got  = 0;
        int   last_pop = -1;
        res_t e;
        for (int c = 0; c < 40 && got < 3; c++) begin
            @(negedge clk);
            a_num_rdy = (c >= 5);
            a_vld = (sent < 3);
            a_vec = '0; a_vec[(sent * 37 + 3) % 96] = 1'b1; a_vec[(sent * 11 + 60) % 96] = 1'b1;
            a_base = 7'(sent * 30); a_mode = sent[0];
            #1;
            if (c >= 2 && c <= 4) begin
                n_tests++;
                if (a_rdy_out !== 1'b0 || sent != 2) begin
                    n_fail++; $display("FAIL bp_full c=%0d ready=%b accepted=%0d exp ready=0 accepted=2", c, a_rdy_out, sent);
                end
                n_tests++;
                if (q_a.size() == 0 || a_num_vld !== 1'b1 || a_got !== q_a[0]) begin
                    n_fail++; $display("FAIL bp_hold c=%0d vld=%b got=%h", c, a_num_vld, a_got);
                end
            end
            if (a_vld && a_rdy_out) begin q_a.push_back(model(a_vec, int'(a_base), a_mode)); sent++; end
            if (a_num_vld && a_num_rdy) begin
                n_tests++;
                if (q_a.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra got=%h", a_got);
                end else begin
                    e = q_a.pop_front();
                    if (a_got !== e || (last_pop >= 0 && cyc != last_pop + 1)) begin
                        n_fail++; $display("FAIL bp_drain%0d got=%h gap=%0d exp=%h gap=1", got, a_got, cyc - last_pop, e);
                    end
                end
                last_pop = cyc;
                got++;
            end
        end
        a_vld = 1'b0; a_num_rdy = 1'b1;
        n_tests++;
        if (got != 3) begin n_fail++; $display("FAIL bp_timeout got=%0d exp=3", got); end
    endtask

    task automatic test_reset_midflight;
        logic stale = 1'b0;
        @(negedge clk);
        a_num_rdy = 1'b0; a_vld = 1'b1; a_vec = '0; a_vec[20] = 1'b1; a_base = '0; a_mode = 1'b0;
        @(negedge clk);
        a_vec = '0; a_vec[30] = 1'b1;
        @(negedge clk);
        rst = 1'b1; a_vec = '0; a_vec[50] = 1'b1;
        #1;
        n_tests++;
        if (a_rdy_out !== 1'b0 || a_num_vld !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre ready=%b vld=%b exp ready=0 vld=1", a_rdy_out, a_num_vld);
        end
        @(negedge clk);
        rst = 1'b0; a_vld = 1'b0; a_num_rdy = 1'b1;
        #1;
        n_tests++;
        if ({a_num_vld, a_got} !== 11'd0) begin n_fail++; $display("FAIL rst_flush got=%b exp=0", {a_num_vld, a_got}); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (a_num_vld !== 1'b0) stale = 1'b1;
        end
        n_tests++;
        if (stale) begin n_fail++; $display("FAIL rst_stale got=1 exp=0"); end
        @(negedge clk);
        a_vld = 1'b1; a_vec = '0; a_vec[77] = 1'b1; a_base = 7'd80; a_mode = 1'b1;
        #1;
        n_tests++;
        if (a_rdy_out !== 1'b1) begin n_fail++; $display("FAIL rst_fresh_accept got=%b exp=1", a_rdy_out); end
        @(negedge clk);
        a_vld = 1'b0;
        #1;
        n_tests++;
        if (a_num_vld !== 1'b0) begin n_fail++; $display("FAIL rst_fresh_early got=%b exp=0", a_num_vld); end
        @(negedge clk); #1;
        n_tests++;
        if (a_num_vld !== 1'b1 || a_got !== {7'd77, 3'b101}) begin
            n_fail++; $display("FAIL rst_fresh_result vld=%b got=%h exp=%h", a_num_vld, a_got, {7'd77, 3'b101});
        end
    endtask

    task automatic test_param16;
        logic [15:0] tv[7];
        logic [3:0]  tbase[7];
        logic        tmode[7];
        res_t        te[7];
        int          sent = 0;
        int          got  = 0;
        res_t        e;
        tv[0] = 16'h1008; tbase[0] = 4'd0;  tmode[0] = 1'b0; te[0] = {7'd15, 3'b110};
        tv[1] = 16'h1008; tbase[1] = 4'd13; tmode[1] = 1'b1; te[1] = {7'd3,  3'b111};
        tv[2] = 16'h1008; tbase[2] = 4'd4;  tmode[2] = 1'b1; te[2] = {7'd12, 3'b110};
        tv[3] = 16'h0200; tbase[3] = 4'd0;  tmode[3] = 1'b0; te[3] = {7'd9,  3'b100};
        tv[4] = 16'h8000; tbase[4] = 4'd15; tmode[4] = 1'b1; te[4] = {7'd15, 3'b100};
        tv[5] = 16'hFFFF; tbase[5] = 4'd7;  tmode[5] = 1'b1; te[5] = {7'd7,  3'b110};
        tv[6] = 16'hFFFF; tbase[6] = 4'd0;  tmode[6] = 1'b0; te[6] = {7'd15, 3'b110};
        b_num_rdy = 1'b1;
        for (int c = 0; c < 40 && got < 7; c++) begin
            @(negedge clk);
            b_vld = (sent < 7);
            if (sent < 7) begin b_vec = tv[sent]; b_base = tbase[sent]; b_mode = tmode[sent]; end
            #1;
            if (b_vld && b_rdy_out) begin q_b.push_back(te[sent]); sent++; end
            if (b_num_vld && b_num_rdy) begin
                n_tests++;
                if (q_b.size() == 0) begin
                    n_fail++; $display("FAIL p16_extra got=%h", b_got);
                end else begin
                    e = q_b.pop_front();
                    if (b_got !== e) begin n_fail++; $display("FAIL p16_case%0d got=%h exp=%h", got, b_got, e); end
                end
                got++;
            end
        end
        b_vld = 1'b0;
        n_tests++;
        if (got != 7) begin n_fail++; $display("FAIL p16_timeout got=%0d exp=7", got); end
    endtask

    task automatic test_random;
        int   sent = 0;
        int   got  = 0;
        res_t e;
        for (int c = 0; c < 600 && !(sent >= 80 && got == sent); c++) begin
            @(negedge clk);
            a_vld = (sent < 80) && ($urandom_range(0, 3) != 0);
            a_num_rdy = (sent >= 80) || ($urandom_range(0, 9) < 7);
            a_vec = {$urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0: a_vec = a_vec & {$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom};
                1: begin a_vec = '0; a_vec[$urandom_range(0, 95)] = 1'b1; end
                2: if ($urandom_range(0, 3) == 0) a_vec = '0;
                default: ;
            endcase
            a_base = 7'($urandom_range(0, 127));
            a_mode = 1'($urandom_range(0, 1));
            #1;
            if (a_vld && a_rdy_out) begin q_a.push_back(model(a_vec, int'(a_base), a_mode)); sent++; end
            if (a_num_vld && a_num_rdy) begin
                n_tests++;
                if (q_a.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra got=%h", a_got);
                end else begin
                    e = q_a.pop_front();
                    if (a_got !== e) begin n_fail++; $display("FAIL rand_item%0d got=%h exp=%h", got, a_got, e); end
                end
                got++;
            end
        end
        a_vld = 1'b0; a_num_rdy = 1'b1;
        n_tests++;
        if (sent != 80 || got != sent) begin n_fail++; $display("FAIL rand_timeout sent=%0d got=%0d exp=80", sent, got); end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_rotate();
        test_backpressure();
        test_reset_midflight();
        test_param16();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
